// File: rtl/ws_drain_pkg.sv
// Shared helpers for the weight-stationary psum drain stage.
// Alignment latency, lane clamp and the wide count type.
package ws_drain_pkg;

   localparam int DRAIN_CNT_W = 16;

   typedef logic [DRAIN_CNT_W-1:0] drain_cnt_t;

   function automatic int drain_align_lat(input int rows, input int pipe_lat);
      return (rows - 1) * (pipe_lat + 1) + pipe_lat + 1;
   endfunction

   // Sign-extend from op_width, then clamp to the signed sat_width range.
   function automatic logic signed [63:0] sat_lane(
      input logic signed [63:0] value,
      input int                 op_width,
      input int                 sat_width
   );
      logic signed [63:0] v;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      v  = value <<< (64 - op_width);
      v  = v >>> (64 - op_width);
      hi = (64'sd1 <<< (sat_width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/ws_drain_fifo.sv
// Synchronous first-word-fall-through FIFO with count/full/empty.
// Depth must be a power of two so the pointers wrap naturally.
module ws_drain_fifo #(
   parameter  int W     = 32,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic [AW:0]  count_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push, pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign pop     = rd_en_i & ~empty_o;
   // A write into a full FIFO only lands if a pop frees the slot.
   assign push    = wr_en_i & (~full_o | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o   = cnt_q;

endmodule

// File: rtl/ws_psum_drain.sv
// Deskews the bottom-row psums into aligned vectors and buffers them.
// Define WS_DRAIN_SAT_EN to clamp each lane to SAT_WIDTH signed bits.
module ws_psum_drain
   import ws_drain_pkg::*;
#(
   parameter  int ROWS       = 64,
   parameter  int COLS       = 64,
   parameter  int OP_WIDTH   = 32,
   parameter  int PIPE_LAT   = 3,
   parameter  int FIFO_DEPTH = 8,
   parameter  int SAT_WIDTH  = 16,
   localparam int ALIGN_LAT  = drain_align_lat(ROWS, PIPE_LAT),
   localparam int VLEN       = ALIGN_LAT + COLS - 1,
   localparam int VW         = COLS * OP_WIDTH,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1,
   localparam int IW         = $clog2(ALIGN_LAT + COLS + 1) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tok_valid,
   input  logic [VW-1:0] psum_row,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [VW-1:0] out_data,
   output logic [CW-1:0] fifo_count,
   output logic [IW-1:0] inflight,
   output logic          issue_ok,
   output logic          overflow
);

`ifdef WS_DRAIN_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic [VLEN-1:0] vpipe_q;
   logic            wr_en;
   logic [VW-1:0]   wr_vec;
   logic [IW-1:0]   inflight_q, inflight_d;
   logic            overflow_q, overflow_d;
   logic            fifo_full, fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) vpipe_q <= '0;
      else     vpipe_q <= {vpipe_q[VLEN-2:0], tok_valid};
   end

   assign wr_en = vpipe_q[VLEN-1];

   // Lane j arrives j cycles after lane 0, so it waits COLS-1-j cycles.
   for (genvar j = 0; j < COLS; j++) begin : g_lane
      localparam int D = COLS - 1 - j;
      logic [OP_WIDTH-1:0] lane;
      logic signed [63:0]  sat_full;
      logic                unused_sat;

      if (D == 0) begin : g_direct
         assign lane = psum_row[j*OP_WIDTH +: OP_WIDTH];
      end else begin : g_dly
         logic [OP_WIDTH-1:0] dly_q [D];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < D; k++) dly_q[k] <= '0;
            end else begin
               dly_q[0] <= psum_row[j*OP_WIDTH +: OP_WIDTH];
               for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
            end
         end
         assign lane = dly_q[D-1];
      end

      assign sat_full   = sat_lane(64'(lane), OP_WIDTH, SAT_WIDTH);
      assign unused_sat = ^sat_full;
      assign wr_vec[j*OP_WIDTH +: OP_WIDTH] =
         SAT_EN ? sat_full[OP_WIDTH-1:0] : lane;
   end

   ws_drain_fifo #(
      .W     (VW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_vec),
      .rd_en_i   (out_ready),
      .rd_data_o (out_data),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign out_valid = ~fifo_empty;

   always_comb begin
      inflight_d = inflight_q;
      overflow_d = overflow_q | (wr_en & fifo_full & ~out_ready);
      unique case ({tok_valid, wr_en})
         2'b10:   inflight_d = inflight_q + IW'(1);
         2'b01:   inflight_d = inflight_q - IW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         overflow_q <= overflow_d;
      end
   end

   assign inflight = inflight_q;
   assign overflow = overflow_q;
   assign issue_ok = (drain_cnt_t'(fifo_count) + drain_cnt_t'(inflight_q))
                     < drain_cnt_t'(FIFO_DEPTH);

endmodule

// File: tb/tb_ws_psum_drain.sv
// Randomised scoreboard bench for ws_psum_drain (4x4 array, depth-4 FIFO).
// Expected vectors and occupancy come from a token-level model.
module tb_ws_psum_drain;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int OW   = 32;
   localparam int PL   = 3;
   localparam int FD   = 4;
   localparam int AL   = (ROWS - 1) * (PL + 1) + PL + 1;
   localparam int LAT  = AL + COLS - 1;
   localparam int VW   = COLS * OW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tok_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [VW-1:0] psum_row = '0;
   logic          out_valid;
   logic [VW-1:0] out_data;
   logic [$clog2(FD):0]        fifo_count;
   logic [$clog2(AL+COLS+1):0] inflight;
   logic          issue_ok;
   logic          overflow;

   ws_psum_drain #(
      .ROWS(ROWS), .COLS(COLS), .OP_WIDTH(OW), .PIPE_LAT(PL),
      .FIFO_DEPTH(FD), .SAT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .tok_valid(tok_valid), .psum_row(psum_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fifo_count(fifo_count), .inflight(inflight),
      .issue_ok(issue_ok), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [VW-1:0] v;
      int            we;
   } pend_t;

   pend_t         pend[$];
   logic [VW-1:0] exp_q[$];
   logic [OW-1:0] sched[int];
   int            cyc = 0;
   int            m_cnt = 0;
   int            m_inf = 0;
   int            m_ovf = 0;
   bit            armed = 1'b0;
   int            n_pass = 0;
   int            n_tot = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic logic [VW-1:0] exp_vec(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      r = v;
`ifdef WS_DRAIN_SAT_EN
      for (int j = 0; j < COLS; j++) begin
         longint x;
         x = longint'(signed'(v[j*OW +: OW]));
         if (x > 32767) x = 32767;
         else if (x < -32768) x = -32768;
         r[j*OW +: OW] = OW'(x);
      end
`endif
      return r;
   endfunction

   // Token-level model: at each negedge compare, then apply the coming edge.
   bit    mp, mw;
   pend_t mpe;
   always @(negedge clk) begin
      if (armed) begin
         chk("out_valid",  int'(out_valid),  int'(m_cnt != 0));
         chk("fifo_count", int'(fifo_count), m_cnt);
         chk("inflight",   int'(inflight),   m_inf);
         chk("issue_ok",   int'(issue_ok),   int'((m_cnt + m_inf) < FD));
         chk("overflow",   int'(overflow),   m_ovf);
      end
      if (rst) begin
         m_cnt = 0;
         m_inf = 0;
         m_ovf = 0;
         pend.delete();
         exp_q.delete();
         armed = 1'b1;
      end else if (armed) begin
         mp = out_ready && (m_cnt > 0);
         mw = (pend.size() > 0) && (pend[0].we == cyc + 1);
         if (mw) begin
            mpe = pend.pop_front();
            if (m_cnt < FD || mp) begin
               exp_q.push_back(mpe.v);
               m_cnt++;
            end else begin
               m_ovf = 1;
            end
         end
         if (mp) m_cnt--;
         m_inf = m_inf + int'(tok_valid) - int'(mw);
      end
   end

   // Monitor: every accepted output vector must be the oldest expected one.
   always @(negedge clk) begin
      if (armed && !rst && out_valid && out_ready) begin
         n_tot++;
         if (exp_q.size() == 0) begin
            $display("FAIL out_data: got %h expected nothing", out_data);
         end else if (out_data === exp_q[0]) begin
            n_pass++;
            void'(exp_q.pop_front());
         end else begin
            $display("FAIL out_data: got %h expected %h", out_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   // One cycle of stimulus; e is the edge that samples these inputs.
   task automatic step(input bit tv, input bit rdy, input bit r,
                       input logic [VW-1:0] v, output int e);
      int key;
      @(posedge clk);
      #1;
      e = cyc + 1;
      rst = r;
      out_ready = rdy;
      tok_valid = tv;
      if (tv && !r) begin
         pend.push_back('{exp_vec(v), e + LAT});
         for (int j = 0; j < COLS; j++)
            sched[(e + AL + j) * COLS + j] = v[j*OW +: OW];
      end
      for (int j = 0; j < COLS; j++) begin
         key = e * COLS + j;
         if (sched.exists(key)) begin
            psum_row[j*OW +: OW] = sched[key];
            sched.delete(key);
         end else begin
            psum_row[j*OW +: OW] = $urandom;
         end
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      int e;
      for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, '0, e);
   endtask

   task automatic do_reset();
      int e;
      step(1'b0, 1'b0, 1'b1, '0, e);
      step(1'b0, 1'b0, 1'b1, '0, e);
      step(1'b0, 1'b0, 1'b0, '0, e);
   endtask

   function automatic logic [VW-1:0] rvec();
      logic [VW-1:0] v;
      for (int j = 0; j < COLS; j++) v[j*OW +: OW] = $urandom;
      return v;
   endfunction

   initial begin
      int e, e0, first_v, first_z, run, max_run, seen;
      logic [VW-1:0] v;

      // Reset state
      do_reset();
      chk("rst out_valid",  int'(out_valid),  0);
      chk("rst out_data",   int'(out_data != '0), 0);
      chk("rst fifo_count", int'(fifo_count), 0);
      chk("rst inflight",   int'(inflight),   0);
      chk("rst overflow",   int'(overflow),   0);
      chk("rst issue_ok",   int'(issue_ok),   1);

      // Single token: lanes 100+j, write after LAT edges
      v = {32'd103, 32'd102, 32'd101, 32'd100};
      step(1'b1, 1'b0, 1'b0, v, e0);
      first_v = -1;
      first_z = -1;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0, 1'b0, '0, e);
         if (out_valid && first_v < 0) first_v = cyc;
         if (inflight == '0 && first_z < 0) first_z = cyc;
      end
      chk("t1 valid latency", first_v - e0, LAT);
      chk("t1 inflight drop", first_z - e0, LAT);
      chk("t1 lane0", int'(out_data[31:0]), 100);
      chk("t1 lane3", int'(out_data[127:96]), 103);
      idle(3, 1'b1);

      // Back-to-back tokens, always ready: no bubbles
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, rvec(), e);
      run = 0;
      max_run = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b1, 1'b0, '0, e);
         if (out_valid) run++;
         else run = 0;
         if (run > max_run) max_run = run;
      end
      chk("t2 valid run", max_run, 4);

      // Fill with no consumer, then force a fifth token
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, rvec(), e);
      step(1'b0, 1'b0, 1'b0, '0, e);
      chk("t3 issue_ok", int'(issue_ok), 0);
      step(1'b1, 1'b0, 1'b0, rvec(), e);
      idle(LAT + 4, 1'b0);
      chk("t3 overflow", int'(overflow), 1);
      chk("t3 count", int'(fifo_count), FD);
      idle(8, 1'b1);

      // Full FIFO: pop on the same edge as the fifth write
      do_reset();
      step(1'b1, 1'b0, 1'b0, rvec(), e0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, rvec(), e);
      for (int i = 0; i < LAT + 3; i++) begin
         step(1'b0, (cyc + 2) == (e0 + LAT + 4), 1'b0, '0, e);
      end
      chk("t4 count", int'(fifo_count), FD);
      chk("t4 overflow", int'(overflow), 0);
      idle(8, 1'b1);

      // Reset with 2 buffered and 3 in flight
      do_reset();
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, rvec(), e);
      idle(LAT + 2, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rvec(), e);
      idle(3, 1'b0);
      step(1'b0, 1'b0, 1'b1, '0, e);
      step(1'b0, 1'b1, 1'b0, '0, e);
      chk("t5 out_valid", int'(out_valid), 0);
      chk("t5 fifo_count", int'(fifo_count), 0);
      chk("t5 inflight", int'(inflight), 0);
      seen = 0;
      for (int i = 0; i < LAT + 10; i++) begin
         step(1'b0, 1'b1, 1'b0, '0, e);
         if (out_valid) seen++;
      end
      chk("t5 late writes", seen, 0);

      // Clamp boundary lanes (pass-through without the macro)
      v = {32'd70000, -32'sd70000, 32'd5, -32'sd5};
      step(1'b1, 1'b1, 1'b0, v, e);
      idle(LAT + 4, 1'b1);

      // Random traffic, mostly honouring issue_ok
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 4 != 0) &&
              (((m_cnt + m_inf) < FD) || ($urandom % 16 == 0)),
              ($urandom % 3 != 0), 1'b0, rvec(), e);
      end
      idle(LAT + 12, 1'b1);
      chk("drain exp_q", exp_q.size(), 0);
      chk("drain pend", pend.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
